// File: rtl/vga_vram_scan.sv
// vga_vram_scan
//   Display-side VRAM reader. Generates VGA raster timing (640x480@60 by
//   default) on clk25M, publishes the undelayed raster position to the game
//   logic, issues one VRAM read per visible pixel and lines the returned
//   colour up with delayed copies of the syncs.
//
// Ports
//   clk25M      in   1   pixel clock, the only clock
//   reset_n     in   1   asynchronous assert, synchronous release, active low
//   scan_en     in   1   1 = run the raster, 0 = hold the raster at (0,0)
//   whpos       out  10  horizontal counter, undelayed
//   wvpos       out  10  vertical counter, undelayed
//   vram_raddr  out  19  read address, wvpos*H_ACTIVE + whpos while active
//   vram_ren    out  1   read strobe, high on visible pixels only
//   vram_rdata  in   12  colour {R4,G4,B4}, valid RD_LAT clocks after vram_ren
//   vga_r/g/b   out  4   colour, zero outside the active area
//   vga_hsync   out  1   horizontal sync, active low
//   vga_vsync   out  1   vertical sync, active low
//   frame_tick  out  1   one-clock pulse at (0, V_ACTIVE), start of vblank
//
// Read protocol: vram_ren is a request with no back-pressure. Whenever it is
// high in cycle t, the memory presents the word at vram_raddr on vram_rdata in
// cycle t+RD_LAT; nothing is returned for cycles where vram_ren is low.
// RD_LAT must lie in 1..4.

module vga_vram_scan #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int RD_LAT   = 1
) (
  input  logic        clk25M,
  input  logic        reset_n,
  input  logic        scan_en,
  output logic [9:0]  whpos,
  output logic [9:0]  wvpos,
  output logic [18:0] vram_raddr,
  output logic        vram_ren,
  input  logic [11:0] vram_rdata,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        frame_tick
);

  localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0] H_PX_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_PX_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic [18:0] addr_cnt;
  logic        run_q;
  logic        run;
  logic        active;
  logic        line_end;
  logic        frame_end;
  logic        last_px;
  logic        hs_raw;
  logic        vs_raw;
  logic [RD_LAT-1:0] de_d;
  logic [RD_LAT-1:0] hs_d;
  logic [RD_LAT-1:0] vs_d;

  // run_q is a registered copy of scan_en. After reset release or a rising
  // scan_en the raster spends one clock parked at (0,0) with no read issued,
  // then pixel (0,0) is shown on the following clock. A falling scan_en stops
  // reads and syncs immediately through the combinational term.
  always_ff @(posedge clk25M or negedge reset_n) begin
    if (!reset_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= scan_en;
    end
  end

  assign run       = run_q && scan_en;
  assign active    = run && (hcnt < H_ACT) && (vcnt < V_ACT);
  assign line_end  = (hcnt == H_LAST);
  assign frame_end = line_end && (vcnt == V_LAST);
  assign last_px   = (hcnt == H_PX_LAST) && (vcnt == V_PX_LAST);
  assign hs_raw    = !(run && (hcnt >= HS_START) && (hcnt <= HS_END));
  assign vs_raw    = !(run && (vcnt >= VS_START) && (vcnt <= VS_END));

  // Raster counters.
  always_ff @(posedge clk25M or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= 10'd0;
      vcnt <= 10'd0;
    end else if (!run) begin
      hcnt <= 10'd0;
      vcnt <= 10'd0;
    end else if (line_end) begin
      hcnt <= 10'd0;
      vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  // Linear read address. It advances after every visible pixel except the
  // last one of the frame, so it sits at the next line's first address during
  // horizontal blanking and at the final pixel address through vblank; it
  // never goes past H_ACTIVE*V_ACTIVE-1.
  always_ff @(posedge clk25M or negedge reset_n) begin
    if (!reset_n) begin
      addr_cnt <= 19'd0;
    end else if (!run || frame_end) begin
      addr_cnt <= 19'd0;
    end else if (active && !last_px) begin
      addr_cnt <= addr_cnt + 19'd1;
    end
  end

  // Data-enable and syncs delayed by the read latency so the last stage lines
  // up with the colour word arriving on vram_rdata.
  always_ff @(posedge clk25M or negedge reset_n) begin
    if (!reset_n) begin
      de_d <= '0;
      hs_d <= '1;
      vs_d <= '1;
    end else begin
      de_d[0] <= active;
      hs_d[0] <= hs_raw;
      vs_d[0] <= vs_raw;
      for (int i = 1; i < RD_LAT; i++) begin
        de_d[i] <= de_d[i-1];
        hs_d[i] <= hs_d[i-1];
        vs_d[i] <= vs_d[i-1];
      end
    end
  end

  assign whpos      = hcnt;
  assign wvpos      = vcnt;
  assign vram_raddr = addr_cnt;
  assign vram_ren   = active;
  assign frame_tick = run && (hcnt == 10'd0) && (vcnt == V_ACT);
  assign vga_hsync  = hs_d[RD_LAT-1];
  assign vga_vsync  = vs_d[RD_LAT-1];
  assign {vga_r, vga_g, vga_b} = de_d[RD_LAT-1] ? vram_rdata : 12'h000;

endmodule

// File: tb/tb_vga_vram_scan.sv
// Bench for vga_vram_scan: one full-size instance (RD_LAT=1) and two reduced
// geometry instances (RD_LAT=1 and RD_LAT=3), each with a RAM that returns
// raddr[11:0] after the instance's read latency.

module tb_vga_vram_scan;

  localparam int S_HA = 16, S_HFP = 4, S_HS = 6, S_HBP = 4;
  localparam int S_VA = 10, S_VFP = 2, S_VS = 2, S_VBP = 3;
  localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
  localparam int S_FT = S_HT * (S_VA + S_VFP + S_VS + S_VBP);

  // {whpos, wvpos, raddr, ren, hsync, vsync, rgb, tick}
  localparam logic [54:0] RESET_VEC = {10'd0, 10'd0, 19'd0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0};

  typedef struct { int ha; int hfp; int hs; int hbp; int va; int vfp; int vs; int vbp; } cfg_t;
  typedef struct { int h; int v; int addr; bit act; bit hs; bit vs; bit tick; } pos_t;

  logic clk25M;
  logic reset_n;
  logic scan_en;

  logic [9:0] f_whpos, f_wvpos, a_whpos, a_wvpos, b_whpos, b_wvpos;
  logic [18:0] f_raddr, a_raddr, b_raddr;
  logic f_ren, a_ren, b_ren;
  logic [11:0] f_rdata, a_rdata, b_rdata, b_p1, b_p2;
  logic [3:0] f_r, f_g, f_b, a_r, a_g, a_b, b_r, b_g, b_b;
  logic f_hs, f_vs, f_tick, a_hs, a_vs, a_tick, b_hs, b_vs, b_tick;

  logic [54:0] obs [3];
  logic [11:0] exp_q[$];

  cfg_t cfg_f, cfg_s;
  int n;
  int errors;
  int checks;

  vga_vram_scan #(.RD_LAT(1)) dut_f (
    .clk25M(clk25M), .reset_n(reset_n), .scan_en(scan_en),
    .whpos(f_whpos), .wvpos(f_wvpos), .vram_raddr(f_raddr), .vram_ren(f_ren),
    .vram_rdata(f_rdata), .vga_r(f_r), .vga_g(f_g), .vga_b(f_b),
    .vga_hsync(f_hs), .vga_vsync(f_vs), .frame_tick(f_tick));

  vga_vram_scan #(.H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
                  .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
                  .RD_LAT(1)) dut_a (
    .clk25M(clk25M), .reset_n(reset_n), .scan_en(scan_en),
    .whpos(a_whpos), .wvpos(a_wvpos), .vram_raddr(a_raddr), .vram_ren(a_ren),
    .vram_rdata(a_rdata), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
    .vga_hsync(a_hs), .vga_vsync(a_vs), .frame_tick(a_tick));

  vga_vram_scan #(.H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
                  .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
                  .RD_LAT(3)) dut_b (
    .clk25M(clk25M), .reset_n(reset_n), .scan_en(scan_en),
    .whpos(b_whpos), .wvpos(b_wvpos), .vram_raddr(b_raddr), .vram_ren(b_ren),
    .vram_rdata(b_rdata), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
    .vga_hsync(b_hs), .vga_vsync(b_vs), .frame_tick(b_tick));

  assign obs[0] = {f_whpos, f_wvpos, f_raddr, f_ren, f_hs, f_vs, f_r, f_g, f_b, f_tick};
  assign obs[1] = {a_whpos, a_wvpos, a_raddr, a_ren, a_hs, a_vs, a_r, a_g, a_b, a_tick};
  assign obs[2] = {b_whpos, b_wvpos, b_raddr, b_ren, b_hs, b_vs, b_r, b_g, b_b, b_tick};

  // RAM models: the word read is the low 12 bits of the address.
  initial begin
    f_rdata = 12'h0; a_rdata = 12'h0; b_rdata = 12'h0; b_p1 = 12'h0; b_p2 = 12'h0;
  end
  always @(posedge clk25M) begin
    f_rdata <= f_raddr[11:0];
    a_rdata <= a_raddr[11:0];
    b_p1    <= b_raddr[11:0];
    b_p2    <= b_p1;
    b_rdata <= b_p2;
  end

  // Clock and reset.
  initial clk25M = 1'b0;
  always #5 clk25M = ~clk25M;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at n=%0d", n);
    $fatal(1, "watchdog");
  end

  // Reference: position n clocks after the raster started at (0,0).
  function automatic pos_t ref_pos(input int cyc, input cfg_t c);
    pos_t p;
    int ht, vt, f;
    ht = c.ha + c.hfp + c.hs + c.hbp;
    vt = c.va + c.vfp + c.vs + c.vbp;
    f = cyc % (ht * vt);
    p.h = f % ht;
    p.v = f / ht;
    p.act = (p.h < c.ha) && (p.v < c.va);
    if (p.act) p.addr = p.v * c.ha + p.h;
    else if (p.v < c.va - 1) p.addr = (p.v + 1) * c.ha;
    else p.addr = c.va * c.ha - 1;
    p.hs = !((p.h >= c.ha + c.hfp) && (p.h < c.ha + c.hfp + c.hs));
    p.vs = !((p.v >= c.va + c.vfp) && (p.v < c.va + c.vfp + c.vs));
    p.tick = (p.h == 0) && (p.v == c.va);
    return p;
  endfunction

  // Full expected output vector of instance d at raster cycle cyc.
  function automatic logic [54:0] exp_vec(input int cyc, input int d);
    cfg_t c;
    pos_t p, q;
    int lat;
    logic hs, vs;
    logic [11:0] rgb;
    c = (d == 0) ? cfg_f : cfg_s;
    lat = (d == 2) ? 3 : 1;
    p = ref_pos(cyc, c);
    if (cyc < lat) begin
      hs = 1'b1; vs = 1'b1; rgb = 12'h000;
    end else begin
      q = ref_pos(cyc - lat, c);
      hs = q.hs; vs = q.vs;
      rgb = q.act ? 12'(q.addr) : 12'h000;
    end
    return {10'(p.h), 10'(p.v), 19'(p.addr), p.act, hs, vs, rgb, p.tick};
  endfunction

  task automatic tick();
    @(negedge clk25M);
    #1;
    n++;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    scan_en = 1'b1;
    #2;
    reset_n = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs[d] !== RESET_VEC) begin
          errors++;
          $display("FAIL reset_hold dut%0d cyc%0d: got %h expected %h", d, k, obs[d], RESET_VEC);
        end
      end
    end
    reset_n = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs[d] !== RESET_VEC) begin
        errors++;
        $display("FAIL reset_release dut%0d: got %h expected %h", d, obs[d], RESET_VEC);
      end
    end
    n = -1;
    for (int k = 0; k < 6; k++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs[d] !== exp_vec(n, d)) begin
          errors++;
          $display("FAIL reset_start dut%0d n=%0d: got %h expected %h", d, n, obs[d], exp_vec(n, d));
        end
      end
    end
  endtask

  task automatic test_line_timing();
    int fall_n, falls, low_run;
    logic prev_hs;
    fall_n = -1; falls = 0; low_run = 0; prev_hs = f_hs;
    while (n < 3 * 800 + 10) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs[d] !== exp_vec(n, d)) begin
          errors++;
          $display("FAIL line_raster dut%0d n=%0d: got %h expected %h", d, n, obs[d], exp_vec(n, d));
        end
      end
      if (n == 639) begin
        checks++;
        if (f_raddr !== 19'd639) begin
          errors++;
          $display("FAIL raddr_639_0: got %0d expected 639", f_raddr);
        end
      end
      if (n == 800) begin
        checks++;
        if (f_raddr !== 19'd640) begin
          errors++;
          $display("FAIL raddr_0_1: got %0d expected 640", f_raddr);
        end
      end
      if (prev_hs && !f_hs) begin
        if (falls > 0) begin
          checks++;
          if (n - fall_n != 800) begin
            errors++;
            $display("FAIL hsync_period: got %0d expected 800", n - fall_n);
          end
        end
        falls++;
        fall_n = n;
        low_run = 0;
      end
      if (!f_hs) low_run++;
      if (!prev_hs && f_hs && fall_n >= 0) begin
        checks++;
        if (low_run != 96) begin
          errors++;
          $display("FAIL hsync_width: got %0d expected 96", low_run);
        end
      end
      prev_hs = f_hs;
    end
    checks++;
    if (falls != 3) begin
      errors++;
      $display("FAIL hsync_count: got %0d expected 3", falls);
    end
  endtask

  task automatic test_frames();
    pos_t p;
    int vs_fall[3], vs_falls[3], vs_low[3], tick_hi[3];
    logic vs_prev[3], tick_prev[3];
    logic [11:0] e;
    for (int d = 1; d < 3; d++) begin
      vs_fall[d] = -1; vs_falls[d] = 0; vs_low[d] = 0; tick_hi[d] = 0;
      vs_prev[d] = obs[d][13]; tick_prev[d] = obs[d][0];
    end
    exp_q.delete();
    for (int k = n - 2; k <= n; k++) begin
      p = ref_pos(k, cfg_s);
      exp_q.push_back(p.act ? 12'(p.addr) : 12'h000);
    end
    for (int k = 0; k < 3 * S_FT; k++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs[d] !== exp_vec(n, d)) begin
          errors++;
          $display("FAIL frame_raster dut%0d n=%0d: got %h expected %h", d, n, obs[d], exp_vec(n, d));
        end
      end
      p = ref_pos(n, cfg_s);
      exp_q.push_back(p.act ? 12'(p.addr) : 12'h000);
      e = exp_q.pop_front();
      checks++;
      if (obs[2][12:1] !== e) begin
        errors++;
        $display("FAIL lat3_rgb n=%0d: got %h expected %h", n, obs[2][12:1], e);
      end
      if (p.h == S_HA - 1 && p.v == S_VA - 1) begin
        checks++;
        if (a_raddr !== 19'(S_HA * S_VA - 1)) begin
          errors++;
          $display("FAIL raddr_last: got %0d expected %0d", a_raddr, S_HA * S_VA - 1);
        end
      end
      if (p.h == 0 && p.v == 0) begin
        checks++;
        if (b_raddr !== 19'd0) begin
          errors++;
          $display("FAIL raddr_wrap: got %0d expected 0", b_raddr);
        end
      end
      for (int d = 1; d < 3; d++) begin
        if (obs[d][0]) begin
          checks++;
          if (tick_prev[d] || obs[d][54:35] !== {10'd0, 10'(S_VA)}) begin
            errors++;
            $display("FAIL tick_pos dut%0d: got prev=%0b pos=%h expected prev=0 pos=%h",
                     d, tick_prev[d], obs[d][54:35], {10'd0, 10'(S_VA)});
          end
          tick_hi[d]++;
        end
        tick_prev[d] = obs[d][0];
        if (vs_prev[d] && !obs[d][13]) begin
          if (vs_fall[d] >= 0) begin
            checks++;
            if (n - vs_fall[d] != S_FT) begin
              errors++;
              $display("FAIL vsync_period dut%0d: got %0d expected %0d", d, n - vs_fall[d], S_FT);
            end
          end
          vs_falls[d]++;
          vs_fall[d] = n;
          vs_low[d] = 0;
        end
        if (!obs[d][13]) vs_low[d]++;
        if (!vs_prev[d] && obs[d][13] && vs_fall[d] >= 0) begin
          checks++;
          if (vs_low[d] != S_VS * S_HT) begin
            errors++;
            $display("FAIL vsync_width dut%0d: got %0d expected %0d", d, vs_low[d], S_VS * S_HT);
          end
        end
        vs_prev[d] = obs[d][13];
      end
    end
    for (int d = 1; d < 3; d++) begin
      checks++;
      if (tick_hi[d] != 3) begin
        errors++;
        $display("FAIL tick_count dut%0d: got %0d expected 3", d, tick_hi[d]);
      end
      checks++;
      if (vs_falls[d] != 3) begin
        errors++;
        $display("FAIL vsync_count dut%0d: got %0d expected 3", d, vs_falls[d]);
      end
    end
  endtask

  task automatic test_disrupt_reset();
    pos_t p;
    int th, tv, guard, hold;
    th = $urandom_range(S_HT - 1, 0);
    tv = $urandom_range(S_VA - 1, 1);
    hold = $urandom_range(5, 1);
    guard = 0;
    do begin
      tick();
      guard++;
      p = ref_pos(n, cfg_s);
    end while (!(p.h == th && p.v == tv) && guard < 2 * S_FT);
    checks++;
    if (obs[1][54:35] !== {10'(th), 10'(tv)}) begin
      errors++;
      $display("FAIL disrupt_pos: got %h expected %h", obs[1][54:35], {10'(th), 10'(tv)});
    end
    reset_n = 1'b0;
    #1;
    for (int k = 0; k <= hold; k++) begin
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs[d] !== RESET_VEC) begin
          errors++;
          $display("FAIL disrupt_hold dut%0d: got %h expected %h", d, obs[d], RESET_VEC);
        end
      end
      if (k < hold) tick();
    end
    reset_n = 1'b1;
    #1;
    n = -1;
    for (int k = 0; k < 3 * S_HT; k++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs[d] !== exp_vec(n, d)) begin
          errors++;
          $display("FAIL disrupt_restart dut%0d n=%0d: got %h expected %h", d, n, obs[d], exp_vec(n, d));
        end
      end
    end
  endtask

  task automatic test_scan_en();
    int run_len;
    run_len = $urandom_range(400, 50);
    for (int k = 0; k < run_len; k++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs[d] !== exp_vec(n, d)) begin
          errors++;
          $display("FAIL pre_disable dut%0d n=%0d: got %h expected %h", d, n, obs[d], exp_vec(n, d));
        end
      end
    end
    scan_en = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs[d][15] !== 1'b0) begin
        errors++;
        $display("FAIL disable_ren dut%0d: got %0b expected 0", d, obs[d][15]);
      end
    end
    for (int k = 1; k <= 50; k++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs[d][54:15] !== 40'd0 || obs[d][0] !== 1'b0) begin
          errors++;
          $display("FAIL disable_hold dut%0d cyc%0d: got %h expected 0", d, k, obs[d][54:15]);
        end
        if (k >= 5) begin
          checks++;
          if (obs[d] !== RESET_VEC) begin
            errors++;
            $display("FAIL disable_idle dut%0d cyc%0d: got %h expected %h", d, k, obs[d], RESET_VEC);
          end
        end
      end
    end
    scan_en = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs[d] !== RESET_VEC) begin
        errors++;
        $display("FAIL enable_park dut%0d: got %h expected %h", d, obs[d], RESET_VEC);
      end
    end
    n = -1;
    for (int k = 0; k < 2 * S_HT + 7; k++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs[d] !== exp_vec(n, d)) begin
          errors++;
          $display("FAIL enable_restart dut%0d n=%0d: got %h expected %h", d, n, obs[d], exp_vec(n, d));
        end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    n = 0;
    cfg_f = '{640, 16, 96, 48, 480, 10, 2, 33};
    cfg_s = '{S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP};
    test_reset();
    test_line_timing();
    test_frames();
    test_disrupt_reset();
    test_scan_en();
    test_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
